hnf_slc_arb: RTL and testbench
==============================

# hnf_slc_arb

Parametrised N-port input arbiter for the HN-F SLC/snoop-filter lookup pipeline. It replaces the hard-wired sharing of one SLC ready between the RXREQ and RXRSP pipe stages. Any number of posted-queue heads compete for the SLC port, with round-robin or aged fixed-priority selection, and the winning flit is delivered through a one-entry registered output stage. It sits between the per-channel RX POSQs and the SLC/SF lookup.

## Interface
- NUM_PORTS, 3: number of competing input channels, 2..8.
- FLIT_W, 128: flit width in bits, carried opaquely.
- MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins) with aging.
- AGE_MAX, 15: in MODE 1, count of consecutive lost cycles after which a port is promoted; 1..255.
- PORT_W, derived: max(1, $clog2(NUM_PORTS)).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  drops the output-stage entry; no input is accepted this cycle.
- in_valid  in  NUM_PORTS  per-port flit valid.
- in_ready  out  NUM_PORTS  per-port accept; at most one bit set.
- in_flit  in  NUM_PORTS*FLIT_W  port i occupies bits [i*FLIT_W +: FLIT_W].
- out_valid  out  1  output stage holds a flit.
- out_ready  in  1  SLC accepts the flit.
- out_flit  out  FLIT_W  registered winning flit.
- out_port  out  PORT_W  index of the source port of out_flit.
- busy  out  1  out_valid OR any in_valid.

## Operation
- can_accept = !flush & (!out_valid | out_ready).
- A grant vector is computed combinationally over in_valid. It is one-hot or zero.
- in_ready[i] = grant[i] & can_accept. The transfer on port i is in_valid[i] & in_ready[i].
- On a transfer, the output stage loads the flit and port index, and out_valid=1.
- If out_valid & out_ready and there is no transfer, out_valid=0.
- Round-robin (MODE 0):
  - A pointer rr_ptr holds the highest-priority port. The search runs rr_ptr, rr_ptr+1, … and wraps at NUM_PORTS-1 → 0.
  - After a transfer from port g, rr_ptr = (g+1) mod NUM_PORTS.
  - rr_ptr is unchanged when there is no transfer, including stalled and flushed cycles.
- Fixed priority with aging (MODE 1):
  - Each port has a counter age[i] of width $clog2(AGE_MAX+1).
  - If the port is valid and not transferred, age[i] increments and saturates at AGE_MAX.
  - age[i] clears when the port transfers or when in_valid[i]=0.
  - Selection: if any port has age==AGE_MAX, the lowest-index such port wins. Otherwise the lowest-index valid port wins.
  - Ages do not advance while can_accept=0. A backpressured SLC is not starvation.
- Flush:
  - Clears out_valid next cycle.
  - Forces in_ready=0 for that cycle.
  - Leaves rr_ptr and age unchanged.
- Inputs must keep in_valid and in_flit stable until accepted. The block does not check this.

## Timing
- Latency is 1 cycle: a flit accepted at edge n appears on out_flit/out_valid after edge n.
- Throughput is 1 flit/cycle. A new flit loads in the same cycle the previous one drains (out_valid & out_ready).
- Reset values: out_valid=0, out_flit=0, out_port=0, rr_ptr=0, all age=0.
- While reset is asserted, in_ready=0 (gated by reset).
- Reset mid-transfer discards the held flit. No flit is emitted after reset deasserts until a new transfer.
- Simultaneous flush and out_ready: the flit is considered dropped, not delivered. out_valid=0 next cycle.
- out_valid, out_flit and out_port are register outputs. in_ready is combinational from in_valid, out_valid, out_ready, flush and reset. There is no path from in_flit to any output in the same cycle.
- NUM_PORTS=1 elaborates as a plain pipe stage with grant = in_valid.

## Structure
- Shared package hnf_arb_pkg:
  - ARB_MODE_RR=0 and ARB_MODE_FIXED_AGED=1 constants.
  - The port-index width function.
- Sub-module hnf_rr_picker (NUM_PORTS parameter): inputs req and base, output one-hot grant. It is a rotating-base priority picker built as a double-width request vector.
- MODE 1 uses the same picker with base=0 on the aged-request vector, falling back to the raw request vector. The top level does the grant selection, rr_ptr/age registers and the output stage.

## Test plan
- RR fairness: NUM_PORTS=3, MODE 0, all ports valid continuously, out_ready=1 → out_port sequence 0,1,2,0,1,2, one flit per cycle after a 1-cycle latency.
- Backpressure: flit A accepted, then out_ready=0 for 4 cycles → out_flit holds A; in_ready=0; rr_ptr unchanged; on release, A drains and B loads in the same cycle.
- Aging: MODE 1, AGE_MAX=3, ports 0 and 2 always valid, out_ready=1 → port 0 wins 3 cycles, port 2 wins the 4th, then port 0 resumes.
- Aging under stall: same setup with out_ready=0 for 10 cycles → age[2] does not advance; the promotion point is unchanged after release.
- Flush: out_valid=1 with flush=1 and out_ready=1 → out_valid=0 next cycle; no in_ready that cycle; rr_ptr unchanged.
- Reset mid-operation: assert reset for 1 cycle with out_valid=1 and inputs valid → out_valid=0, out_port=0, and the next grant goes to port 0.

Source files
------------

// File: rtl/hnf_arb_pkg.sv
// Shared constants and helpers for the HN-F SLC input arbiter.
package hnf_arb_pkg;

  localparam int ARB_MODE_RR         = 0;
  localparam int ARB_MODE_FIXED_AGED = 1;

  // Index width for an n-entry port set, never narrower than one bit.
  function automatic int port_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hnf_rr_picker.sv
// Rotating-base priority picker: first requester at or above base, wrapping,
// found by scanning a doubled copy of the request vector.
module hnf_rr_picker
  import hnf_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  localparam int PW = port_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        base,
  output logic [NUM_PORTS-1:0] grant
);

  logic [2*NUM_PORTS-1:0] dbl;
  logic                   found;

  always_comb begin
    dbl   = {req, req};
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < 2*NUM_PORTS; i++) begin
      if (!found && dbl[i] && (i >= int'(base))) begin
        found                = 1'b1;
        grant[i % NUM_PORTS] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hnf_slc_arb.sv
// N-port arbiter feeding the SLC/SF lookup: round-robin or aged fixed priority,
// with a one-entry registered output stage.
module hnf_slc_arb
  import hnf_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int FLIT_W    = 128,
  parameter int MODE      = 0,
  parameter int AGE_MAX   = 15,
  localparam int PORT_W   = port_w(NUM_PORTS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS-1:0]        in_ready,
  input  logic [NUM_PORTS*FLIT_W-1:0] in_flit,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FLIT_W-1:0]           out_flit,
  output logic [PORT_W-1:0]           out_port,
  output logic                        busy
);

  logic                 can_accept;
  logic                 xfer;
  logic [NUM_PORTS-1:0] grant;
  logic [PORT_W-1:0]    win_idx;
  logic [FLIT_W-1:0]    win_flit;

  assign can_accept = !flush && (!out_valid || out_ready);
  assign in_ready   = (reset || !can_accept) ? '0 : grant;
  assign xfer       = |(in_valid & in_ready);
  assign busy       = out_valid || (|in_valid);

  always_comb begin
    win_idx  = '0;
    win_flit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        win_idx  = PORT_W'(i);
        win_flit = in_flit[i*FLIT_W +: FLIT_W];
      end
    end
  end

  generate
    if (NUM_PORTS == 1) begin : g_single
      assign grant = in_valid;
    end else if (MODE == ARB_MODE_RR) begin : g_rr
      logic [PORT_W-1:0] rr_ptr;

      hnf_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .req   (in_valid),
        .base  (rr_ptr),
        .grant (grant)
      );

      always_ff @(posedge clock) begin
        if (reset) begin
          rr_ptr <= '0;
        end else if (xfer) begin
          rr_ptr <= (win_idx == PORT_W'(NUM_PORTS-1)) ? '0 : win_idx + PORT_W'(1);
        end
      end
    end else begin : g_aged
      localparam int AGE_W = $clog2(AGE_MAX+1);

      logic [AGE_W-1:0]     age [NUM_PORTS];
      logic [NUM_PORTS-1:0] aged_req;
      logic [NUM_PORTS-1:0] grant_aged;
      logic [NUM_PORTS-1:0] grant_raw;

      always_comb begin
        aged_req = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
          aged_req[i] = in_valid[i] && (age[i] == AGE_W'(AGE_MAX));
        end
      end

      hnf_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_pick_aged (
        .req   (aged_req),
        .base  ('0),
        .grant (grant_aged)
      );

      hnf_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_pick_raw (
        .req   (in_valid),
        .base  ('0),
        .grant (grant_raw)
      );

      assign grant = (|aged_req) ? grant_aged : grant_raw;

      // A stalled SLC is not starvation, so ages only advance when a grant could land.
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < NUM_PORTS; i++) age[i] <= '0;
        end else begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (!in_valid[i] || in_ready[i]) begin
              age[i] <= '0;
            end else if (can_accept && (age[i] != AGE_W'(AGE_MAX))) begin
              age[i] <= age[i] + AGE_W'(1);
            end
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_port  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_flit  <= win_flit;
      out_port  <= win_idx;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hnf_slc_arb.sv
// Bench for hnf_slc_arb: one round-robin and one aged instance against a
// behavioural reference model, plus vector tables and hand-written sequences.
module tb_hnf_slc_arb;

  localparam int N      = 3;
  localparam int FW     = 16;
  localparam int AGE_AG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    iv   [2];
  logic [N*FW-1:0] ifl  [2];
  logic            ordy [2];
  logic            fl   [2];
  logic [N-1:0]    ir   [2];
  logic            ov   [2];
  logic [FW-1:0]   of   [2];
  logic [1:0]      op   [2];
  logic            bz   [2];

  hnf_slc_arb #(.NUM_PORTS(N), .FLIT_W(FW), .MODE(0), .AGE_MAX(15)) dut_rr (
    .clock(clk), .reset(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_flit(ifl[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_flit(of[0]),
    .out_port(op[0]), .busy(bz[0]));

  hnf_slc_arb #(.NUM_PORTS(N), .FLIT_W(FW), .MODE(1), .AGE_MAX(AGE_AG)) dut_ag (
    .clock(clk), .reset(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_flit(ifl[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_flit(of[1]),
    .out_port(op[1]), .busy(bz[1]));

  // reference model state, index 0 = round-robin dut, 1 = aged dut
  int            m_ptr  [2];
  int            m_age  [2][N];
  bit            m_ov   [2];
  logic [FW-1:0] m_flit [2];
  int            m_port [2];
  int            m_g    [2];
  bit            m_ca   [2];
  logic [N-1:0]  seen_ir[2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int pick(input int d);
    if (d == 0) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr[d] + k) % N;
        if (iv[d][p]) return p;
      end
    end else begin
      for (int i = 0; i < N; i++) if (iv[d][i] && m_age[d][i] == AGE_AG) return i;
      for (int i = 0; i < N; i++) if (iv[d][i]) return i;
    end
    return -1;
  endfunction

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] e;
      m_ca[d] = !fl[d] && (!m_ov[d] || ordy[d]);
      m_g[d]  = (rst || !m_ca[d]) ? -1 : pick(d);
      e = '0;
      if (m_g[d] >= 0) e[m_g[d]] = 1'b1;
      seen_ir[d] = ir[d];
      chk($sformatf("in_ready[%0d]", d), 32'(ir[d]), 32'(e));
      chk($sformatf("busy[%0d]", d), 32'(bz[d]), 32'(m_ov[d] || (|iv[d])));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_ov[d] = 0; m_flit[d] = '0; m_port[d] = 0; m_ptr[d] = 0;
        for (int i = 0; i < N; i++) m_age[d][i] = 0;
      end else begin
        if (m_g[d] >= 0) begin
          m_ov[d]   = 1;
          m_flit[d] = ifl[d][m_g[d]*FW +: FW];
          m_port[d] = m_g[d];
          if (d == 0) m_ptr[d] = (m_g[d] + 1) % N;
        end else if (fl[d] || ordy[d]) begin
          m_ov[d] = 0;
        end
        if (d == 1) begin
          for (int i = 0; i < N; i++) begin
            if (!iv[d][i] || i == m_g[d]) m_age[d][i] = 0;
            else if (m_ca[d] && m_age[d][i] < AGE_AG) m_age[d][i]++;
          end
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(m_ov[d]));
      chk($sformatf("out_flit[%0d]", d), 32'(of[d]), 32'(m_flit[d]));
      chk($sformatf("out_port[%0d]", d), 32'(op[d]), 32'(m_port[d]));
    end
    @(negedge clk);
  endtask

  // Random source obeying the hold-until-accepted rule.
  task automatic gen(input int d);
    for (int i = 0; i < N; i++) begin
      if (iv[d][i] && m_g[d] == i) begin
        if ($urandom % 2) ifl[d][i*FW +: FW] = 16'($urandom);
        else iv[d][i] = 1'b0;
      end else if (!iv[d][i] && ($urandom % 3) == 0) begin
        iv[d][i] = 1'b1;
        ifl[d][i*FW +: FW] = 16'($urandom);
      end
    end
    ordy[d] = ($urandom % 4) != 0;
    fl[d]   = ($urandom % 16) == 0;
  endtask

  task automatic idle(input int d);
    iv[d] = '0; ordy[d] = 1'b1; fl[d] = 1'b0;
  endtask

  typedef struct {
    bit       rst;
    bit [2:0] iv;
    bit       ordy;
    bit       fl;
    bit [2:0] eir;
    bit       eov;
    bit [1:0] eport;
  } vec_t;

  vec_t tbl[16];
  int   ag_exp[8];
  bit   st_ordy[15];
  int   st_exp[15];

  initial begin
    tbl[0]  = '{0, 3'b111, 1, 0, 3'b001, 1, 2'd0};
    tbl[1]  = '{0, 3'b111, 1, 0, 3'b010, 1, 2'd1};
    tbl[2]  = '{0, 3'b111, 1, 0, 3'b100, 1, 2'd2};
    tbl[3]  = '{0, 3'b111, 1, 0, 3'b001, 1, 2'd0};
    tbl[4]  = '{0, 3'b111, 0, 0, 3'b000, 1, 2'd0};
    tbl[5]  = '{0, 3'b111, 0, 0, 3'b000, 1, 2'd0};
    tbl[6]  = '{0, 3'b111, 1, 0, 3'b010, 1, 2'd1};
    tbl[7]  = '{0, 3'b000, 1, 0, 3'b000, 0, 2'd1};
    tbl[8]  = '{0, 3'b100, 0, 0, 3'b100, 1, 2'd2};
    tbl[9]  = '{0, 3'b011, 1, 1, 3'b000, 0, 2'd2};
    tbl[10] = '{0, 3'b011, 1, 0, 3'b001, 1, 2'd0};
    tbl[11] = '{0, 3'b001, 1, 0, 3'b001, 1, 2'd0};
    tbl[12] = '{1, 3'b111, 1, 0, 3'b000, 0, 2'd0};
    tbl[13] = '{0, 3'b110, 1, 0, 3'b010, 1, 2'd1};
    tbl[14] = '{1, 3'b111, 1, 0, 3'b000, 0, 2'd0};
    tbl[15] = '{0, 3'b111, 1, 0, 3'b001, 1, 2'd0};

    ag_exp = '{0, 0, 0, 2, 0, 0, 0, 2};
    for (int i = 0; i < 15; i++) begin
      st_ordy[i] = !(i >= 1 && i <= 10);
      st_exp[i]  = (i >= 1 && i <= 10) ? -1 : 0;
    end
    st_exp[13] = 2;

    for (int d = 0; d < 2; d++) begin
      m_ov[d] = 0; m_flit[d] = '0; m_port[d] = 0; m_ptr[d] = 0; m_g[d] = -1;
      for (int i = 0; i < N; i++) m_age[d][i] = 0;
      idle(d);
    end
    ifl[0] = {16'hA002, 16'hA001, 16'hA000};
    ifl[1] = {16'hB002, 16'hB001, 16'hB000};
    rst = 1'b1;
    @(negedge clk);
    cycle();
    chk("reset_out_valid", 32'(ov[0]), 32'd0);
    chk("reset_out_port", 32'(op[0]), 32'd0);

    // round-robin vectors: fairness, backpressure, drain+load, flush, reset
    for (int t = 0; t < 16; t++) begin
      rst     = tbl[t].rst;
      iv[0]   = tbl[t].iv;
      ordy[0] = tbl[t].ordy;
      fl[0]   = tbl[t].fl;
      cycle();
      chk($sformatf("tbl%0d_ir", t), 32'(seen_ir[0]), 32'(tbl[t].eir));
      chk($sformatf("tbl%0d_ov", t), 32'(ov[0]), 32'(tbl[t].eov));
      chk($sformatf("tbl%0d_port", t), 32'(op[0]), 32'(tbl[t].eport));
    end
    idle(0);

    // aging: ports 0 and 2 always valid
    rst = 1'b1; cycle(); rst = 1'b0;
    iv[1] = 3'b101; ordy[1] = 1'b1;
    for (int t = 0; t < 8; t++) begin
      cycle();
      chk($sformatf("age%0d_grant", t), 32'(seen_ir[1]), 32'(1) << ag_exp[t]);
    end

    // aging under stall: promotion point must not move
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int t = 0; t < 15; t++) begin
      ordy[1] = st_ordy[t];
      cycle();
      chk($sformatf("stall%0d_grant", t), 32'(seen_ir[1]),
          (st_exp[t] < 0) ? 32'd0 : (32'(1) << st_exp[t]));
    end
    idle(1);
    rst = 1'b1; cycle(); rst = 1'b0;

    // randomized traffic on both instances
    for (int t = 0; t < 600; t++) begin
      gen(0);
      gen(1);
      rst = ($urandom % 128) == 0;
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
